// File: rtl/neuron_accumulator.sv
`default_nettype none
// ============================================================================
// neuron_accumulator : bias + product accumulation, shift rescale, ReLU/sat
// Revision: 1.0
// ============================================================================
module neuron_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 24,
    parameter int SHIFT    = 7,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [15:0]      bias_i,
    input  logic             prod_valid_i,
    input  logic [15:0]      prod_i,
    output logic             busy_o,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int ACC_MIN = 16 + $clog2(N_INPUTS) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         count_q;
    logic                     busy_q;
    logic                     out_valid_q;
    logic [7:0]               out_data_q;

    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  scaled;
    logic                     last_prod;
    logic [7:0]               act_d;

    assign bias_ext  = {{(ACC_W-16){bias_i[15]}}, bias_i};
    assign prod_ext  = {{(ACC_W-16){prod_i[15]}}, prod_i};
    assign scaled    = acc_q >>> SHIFT;
    assign last_prod = (count_q == CNT_W'(N_INPUTS - 1));

    // Negative clamps to 0; any set bit above the 7-bit magnitude saturates to 127.
    always_comb begin
        act_d = scaled[7:0];
        if (scaled[ACC_W-1])
            act_d = 8'd0;
        else if (|scaled[ACC_W-2:7])
            act_d = 8'd127;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_q   <= bias_ext;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (prod_valid_i) begin
                        acc_q   <= acc_q + prod_ext;
                        count_q <= count_q + CNT_W'(1);
                        if (last_prod)
                            state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    out_data_q  <= act_d;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign count_o     = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (ACC_W >= ACC_MIN)
            else $error("neuron_accumulator: ACC_W=%0d below minimum %0d", ACC_W, ACC_MIN);
    end
`endif

endmodule
`default_nettype wire
